// File: rtl/core_scheduler.sv
// Per-core sequencer: IDLE->FETCH->DECODE->REQUEST->WAIT->EXECUTE->UPDATE, DONE on RET; 6-cycle minimum per instruction.
// Stalls in FETCH on instr_valid and in WAIT on enabled lsu_busy lanes; WAIT_TIMEOUT_EN adds a WAIT watchdog.
module core_scheduler #(
    parameter int THREADS  = 4,
    parameter int PC_W     = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [THREADS-1:0]      thread_enable,
    input  logic                    instr_valid,
    input  logic                    decoded_ret,
    input  logic                    decoded_mem_op,
    input  logic [THREADS-1:0]      lsu_busy,
    input  logic [THREADS*PC_W-1:0] next_pc,
    output logic [2:0]              core_state,
    output logic [PC_W-1:0]         current_pc,
    output logic                    fetch_req,
    output logic                    done,
    output logic [15:0]             instr_count,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    state_t             state, state_nxt;
    logic [THREADS-1:0] mask;
    logic [PC_W-1:0]    sel_pc;
    logic               wait_ok;
    logic               wait_trip;

    assign core_state = state;
    assign wait_ok    = !decoded_mem_op || ((lsu_busy & mask) == '0);

    // Descending scan so the lowest enabled lane wins; lane 0 when nothing is enabled.
    always_comb begin
        sel_pc = next_pc[PC_W-1:0];
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (mask[i]) sel_pc = next_pc[i*PC_W +: PC_W];
        end
    end

`ifdef WAIT_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);
    logic [15:0] wait_cnt;

    assign wait_trip = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != S_WAIT) wait_cnt <= '0;
            else                 wait_cnt <= wait_cnt + 16'd1;
            if (state == S_WAIT && !wait_ok && wait_trip) timeout_err <= 1'b1;
        end
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT == 0);
    assign wait_trip       = 1'b0;
    assign timeout_err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   if (instr_valid) state_nxt = S_DECODE;
            S_DECODE:  state_nxt = S_REQUEST;
            S_REQUEST: state_nxt = S_WAIT;
            S_WAIT: begin
                // Lanes draining in the same cycle beat the watchdog.
                if (wait_ok)        state_nxt = S_EXECUTE;
                else if (wait_trip) state_nxt = S_DONE;
            end
            S_EXECUTE: state_nxt = S_UPDATE;
            S_UPDATE:  state_nxt = decoded_ret ? S_DONE : S_FETCH;
            S_DONE:    state_nxt = S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mask        <= '0;
            current_pc  <= '0;
            instr_count <= '0;
            fetch_req   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_req <= (state_nxt == S_FETCH);
            done      <= (state_nxt == S_DONE);
            if (state == S_IDLE && start) begin
                mask        <= thread_enable;
                current_pc  <= '0;
                instr_count <= '0;
            end
            if (state == S_UPDATE) begin
                if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                if (!decoded_ret) current_pc <= sel_pc;
            end
        end
    end

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboarded bench for core_scheduler: randomized instruction streams plus directed corner runs.
module tb_core_scheduler;
    localparam int THREADS  = 4;
    localparam int PC_W     = 8;
    localparam int MAX_WAIT = 10;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic [THREADS-1:0]      thread_enable;
    logic                    instr_valid;
    logic                    decoded_ret;
    logic                    decoded_mem_op;
    logic [THREADS-1:0]      lsu_busy;
    logic [THREADS*PC_W-1:0] next_pc;
    logic [2:0]              core_state;
    logic [PC_W-1:0]         current_pc;
    logic                    fetch_req;
    logic                    done;
    logic [15:0]             instr_count;
    logic                    timeout_err;

    core_scheduler #(.THREADS(THREADS), .PC_W(PC_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_enable(thread_enable),
        .instr_valid(instr_valid), .decoded_ret(decoded_ret), .decoded_mem_op(decoded_mem_op),
        .lsu_busy(lsu_busy), .next_pc(next_pc), .core_state(core_state),
        .current_pc(current_pc), .fetch_req(fetch_req), .done(done),
        .instr_count(instr_count), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        int              cnt;
        bit              ret;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model of the architectural state.
    logic [THREADS-1:0] m_mask;
    logic [PC_W-1:0]    m_pc;
    int                 m_cnt;

    function automatic void check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endfunction

    function automatic logic [PC_W-1:0] lowest_pc(input logic [THREADS*PC_W-1:0] v,
                                                  input logic [THREADS-1:0] m);
        for (int i = 0; i < THREADS; i++)
            if (m[i]) return v[i*PC_W +: PC_W];
        return v[PC_W-1:0];
    endfunction

    task automatic check_outputs(input string tag, input int st, input int pc, input int cnt,
                                 input int dn, input int fr, input int to);
        check({tag, ".state"},   core_state,  st);
        check({tag, ".pc"},      current_pc,  pc);
        check({tag, ".count"},   instr_count, cnt);
        check({tag, ".done"},    done,        dn);
        check({tag, ".fetch"},   fetch_req,   fr);
        check({tag, ".timeout"}, timeout_err, to);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; instr_valid = 1'b0; decoded_ret = 1'b0;
        decoded_mem_op = 1'b0; lsu_busy = '0; next_pc = '0; thread_enable = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_kernel(input logic [THREADS-1:0] msk);
        @(negedge clk);
        start = 1'b1; thread_enable = msk;
        @(posedge clk); #1;
        start = 1'b0; thread_enable = THREADS'($urandom);
        m_mask = msk; m_pc = '0; m_cnt = 0;
    endtask

    // Drives one instruction reactively and predicts its retirement.
    task automatic run_instr(input int fd, input bit mem, input int nb, input logic [THREADS-1:0] pat,
                             input bit ret, input logic [THREADS*PC_W-1:0] npc);
        exp_t e;
        int   w, f, k, guard;
        bit   seen_upd;
        f = 0; k = 0; guard = 0; seen_upd = 1'b0;
        w = (mem && ((pat & m_mask) != '0) && nb > 0) ? nb + 1 : 1;
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        if (!ret) m_pc = lowest_pc(npc, m_mask);
        e.pc = m_pc; e.cnt = m_cnt; e.ret = ret; e.cyc = fd + 5 + w;
        exp_q.push_back(e);
        decoded_mem_op = mem; decoded_ret = ret; next_pc = npc; lsu_busy = '0; instr_valid = 1'b0;
        while (!seen_upd && guard < 500) begin
            @(negedge clk);
            guard++;
            case (core_state)
                3'd1: begin instr_valid = (f >= fd); f++; end
                3'd4: begin k++; lsu_busy = (k <= nb) ? pat : (pat & ~m_mask); end
                3'd6: seen_upd = 1'b1;
                default: ;
            endcase
        end
        check("instr_reaches_update", seen_upd, 1);
        @(posedge clk); #1;
    endtask

    // Monitor: on each retirement, pop and compare against the prediction.
    initial begin
        logic [2:0] prev;
        int         cyc;
        exp_t       e;
        prev = 3'd0; cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev == 3'd6 && core_state != 3'd6) begin
                    check("retire_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("ret.pc",      current_pc,  e.pc);
                        check("ret.count",   instr_count, e.cnt);
                        check("ret.done",    done,        e.ret);
                        check("ret.fetch",   fetch_req,   !e.ret);
                        check("ret.state",   core_state,  e.ret ? 7 : 1);
                        check("ret.latency", cyc,         e.cyc);
                    end
                end
                if (core_state == 3'd1 && prev != 3'd1) cyc = 0;
                cyc++;
            end
            prev = reset ? 3'd0 : core_state;
        end
    end

    initial begin
        int n, w, guard;
        logic [THREADS-1:0] msk;
        reset = 1'b1; start = 1'b0; thread_enable = '0; instr_valid = 1'b0;
        decoded_ret = 1'b0; decoded_mem_op = 1'b0; lsu_busy = '0; next_pc = '0;
        m_mask = '0; m_pc = '0; m_cnt = 0;

        do_reset();
        @(negedge clk);
        check_outputs("reset", 0, 0, 0, 0, 0, 0);

        // Back-to-back minimum latency, long memory wait, then RET as third instruction.
        start_kernel(4'b1111);
        run_instr(0, 1'b0, 0, 4'b0000, 1'b0, {4{8'h01}});
        run_instr(0, 1'b1, 5, 4'b0110, 1'b0, 32'($urandom));
        run_instr(2, 1'b1, 3, 4'b1001, 1'b1, 32'($urandom));
        @(negedge clk);
        start = 1'b1; thread_enable = 4'b0001; next_pc = 32'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("done_ignores_start", 7, m_pc, 3, 1, 0, 0);

        // Busy lanes outside the mask do not hold WAIT.
        do_reset();
        start_kernel(4'b0011);
        run_instr(0, 1'b1, 8, 4'b1100, 1'b0, 32'($urandom));
        run_instr(1, 1'b1, 2, 4'b0010, 1'b1, 32'($urandom));

        // PC comes from the lowest enabled lane.
        do_reset();
        start_kernel(4'b0100);
        run_instr(1, 1'b0, 0, 4'b0000, 1'b0, {8'h44, 8'h2A, 8'h33, 8'h10});
        run_instr(0, 1'b0, 0, 4'b0000, 1'b1, 32'($urandom));

        // Randomized kernels, including an empty mask.
        for (int kk = 0; kk < 12; kk++) begin
            do_reset();
            msk = (kk == 0) ? 4'b0000 : THREADS'($urandom_range(0, 15));
            start_kernel(msk);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                run_instr($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 6),
                          THREADS'($urandom), (i == n - 1), 32'($urandom));
            repeat (2) @(negedge clk);
            check_outputs("rand_done", 7, m_pc, m_cnt, 1, 0, 0);
        end

        // Reset while stuck in WAIT.
        do_reset();
        start_kernel(4'b1111);
        instr_valid = 1'b1; decoded_mem_op = 1'b1; lsu_busy = 4'b1111;
        guard = 0;
        while (core_state != 3'd4 && guard < 20) begin @(negedge clk); guard++; end
        check("reach_wait_for_reset", core_state, 4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs("reset_mid_wait", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Lane stuck busy: watchdog when compiled in, indefinite WAIT otherwise.
        do_reset();
        start_kernel(4'b1111);
        instr_valid = 1'b1; decoded_mem_op = 1'b1; lsu_busy = 4'b0001; decoded_ret = 1'b0;
        guard = 0;
        while (core_state != 3'd4 && guard < 20) begin @(negedge clk); guard++; end
        check("reach_wait_stuck", core_state, 4);
        w = 1;
`ifdef WAIT_TIMEOUT_EN
        while (core_state == 3'd4 && w < 1100) begin
            @(negedge clk);
            if (core_state == 3'd4) w++;
        end
        check("timeout_wait_cycles", w, MAX_WAIT);
        check_outputs("timeout", 7, 0, 0, 1, 0, 1);
`else
        repeat (1000) @(negedge clk);
        check_outputs("no_timeout", 4, 0, 0, 0, 0, 0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
